// File: rtl/picorv_mem_pkg.sv
// picorv_mem_pkg: shared FSM state type and sizing constants for the picorv32 memory responder
package picorv_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int WORD_BYTES = 4;
    localparam int WAIT_W     = 4;
endpackage

// File: rtl/picorv_mem_bram.sv
// picorv_mem_bram: 2-port byte-write word RAM; port A core r/w, port B load write-only with priority
module picorv_mem_bram
    import picorv_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter     INIT_FILE = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_en_i,
    input  logic                  a_we_i,
    input  logic                  a_zero_i,
    input  logic [ADDR_W-1:0]     a_addr_i,
    input  logic [31:0]           a_wdata_i,
    input  logic [WORD_BYTES-1:0] a_wstrb_i,
    output logic [31:0]           a_rdata_o,
    input  logic                  b_we_i,
    input  logic [ADDR_W-1:0]     b_addr_i,
    input  logic [31:0]           b_wdata_i
);
    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (a_we_i)
            for (int i = 0; i < WORD_BYTES; i++)
                if (a_wstrb_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else if (a_en_i) rdata_q <= a_zero_i ? '0 : mem_q[a_addr_i];
    end

    assign a_rdata_o = rdata_q;
endmodule

// File: rtl/picorv_mem_responder.sv
// picorv_mem_responder: picorv32 native-bus RAM responder with wait states; PICORV_MEM_TRIGGER_EN adds fetch trigger
module picorv_mem_responder
    import picorv_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              mem_valid_i,
    input  logic              mem_instr_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [3:0]        mem_wstrb_i,
    output logic              mem_ready_o,
    output logic [31:0]       mem_rdata_o,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i,
    output logic              err_o,
    input  logic [31:0]       trig_addr_i,
    output logic              trig_o
);
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              err_q;
    logic              accept, in_range;
    logic              unused_addr;

    assign accept      = !reset_i && state_q == IDLE && mem_valid_i;
    assign in_range    = mem_addr_i[31:ADDR_W+2] == '0;
    assign unused_addr = ^mem_addr_i[1:0];

    picorv_mem_bram #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_bram (
        .clk_i     (clk_i),
        .rst_i     (reset_i),
        .a_en_i    (accept),
        .a_we_i    (accept && in_range),
        .a_zero_i  (!in_range || mem_wstrb_i != '0),
        .a_addr_i  (mem_addr_i[ADDR_W+1:2]),
        .a_wdata_i (mem_wdata_i),
        .a_wstrb_i (mem_wstrb_i),
        .a_rdata_o (mem_rdata_o),
        .b_we_i    (ld_we_i),
        .b_addr_i  (ld_addr_i),
        .b_wdata_i (ld_data_i)
    );

    // Next state: accept in IDLE, count down wait states, single RESP cycle back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && accept) begin
            state_d = WAIT_STATES == 0 ? RESP : WAIT;
            cnt_d   = WAIT_W'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
        end else if (state_q == WAIT) begin
            state_d = cnt_q == '0 ? RESP : WAIT;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    // State, wait counter and the range flag latched at acceptance
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) err_q <= !in_range;
        end
    end

    assign mem_ready_o = state_q == RESP;
    assign err_o       = mem_ready_o && err_q;

`ifdef PICORV_MEM_TRIGGER_EN
    logic trig_q;

    // Remember whether the accepted request is an in-range fetch of the trigger address
    always_ff @(posedge clk_i) begin
        if (reset_i) trig_q <= 1'b0;
        else if (accept) trig_q <= mem_instr_i && in_range && mem_addr_i == trig_addr_i;
    end

    assign trig_o = mem_ready_o && trig_q;
`else
    logic unused_trig;

    assign unused_trig = ^{trig_addr_i, mem_instr_i};
    assign trig_o      = 1'b0;
`endif
endmodule

// File: tb/tb_picorv_mem_responder.sv
// tb_picorv_mem_responder: scoreboard bench driving a zero-wait and a three-wait responder in lockstep
module tb_picorv_mem_responder;
`ifdef PICORV_MEM_TRIGGER_EN
    localparam bit TRIG_ON = 1'b1;
`else
    localparam bit TRIG_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        trig;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0, instr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ld_we = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] trig_addr = 32'h20;
    logic        r0, e0, t0, r3, e3, t3;
    logic [31:0] d0, d3;

    logic [31:0] model [1024];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    picorv_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .INIT_FILE("")) u0 (
        .clk_i(clk), .reset_i(reset), .mem_valid_i(valid), .mem_instr_i(instr),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb),
        .mem_ready_o(r0), .mem_rdata_o(d0), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .err_o(e0), .trig_addr_i(trig_addr), .trig_o(t0)
    );

    picorv_mem_responder #(.ADDR_W(10), .WAIT_STATES(3), .INIT_FILE("")) u3 (
        .clk_i(clk), .reset_i(reset), .mem_valid_i(valid), .mem_instr_i(instr),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb),
        .mem_ready_o(r3), .mem_rdata_o(d3), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
        .ld_data_i(ld_data), .err_o(e3), .trig_addr_i(trig_addr), .trig_o(t3)
    );

    task automatic load_word(input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 10'(idx); ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        model[idx] = d;
    endtask

    task automatic run_req(input string name, input logic ins, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input logic coll, input logic [31:0] coll_data);
        exp_t        e, p;
        logic        in_r;
        int          idx;
        logic [31:0] c0;
        logic        ce0, ct0;
        in_r    = a[31:12] == '0;
        idx     = int'(a[11:2]);
        e.name  = name;
        e.rdata = (in_r && ws == 4'h0) ? model[idx] : 32'h0;
        e.err   = !in_r;
        e.trig  = TRIG_ON && ins && in_r && a == trig_addr;
        sb.push_back(e);
        @(negedge clk);
        valid = 1'b1; instr = ins; addr = a; wdata = wd; wstrb = ws;
        if (coll) begin
            ld_we = 1'b1; ld_addr = 10'(idx); ld_data = coll_data;
        end
        if (in_r)
            for (int i = 0; i < 4; i++)
                if (ws[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
        if (coll) model[idx] = coll_data;
        c0 = '0; ce0 = 1'b0; ct0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                valid = 1'b0; ld_we = 1'b0; instr = 1'($urandom);
                addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
            end
            n_cmp += 2;
            if (r0 !== (k == 1)) begin
                n_bad++;
                $display("FAIL %s ready0 k=%0d: got %b want %b", name, k, r0, k == 1);
            end
            if (r3 !== (k == 4)) begin
                n_bad++;
                $display("FAIL %s ready3 k=%0d: got %b want %b", name, k, r3, k == 4);
            end
            if (k == 1) begin
                c0 = d0; ce0 = e0; ct0 = t0;
            end
            if (k == 4 && sb.size() > 0) begin
                p = sb.pop_front();
                n_cmp += 6;
                if (c0 !== p.rdata) begin n_bad++; $display("FAIL %s rdata0: got %h want %h", p.name, c0, p.rdata); end
                if (ce0 !== p.err) begin n_bad++; $display("FAIL %s err0: got %b want %b", p.name, ce0, p.err); end
                if (ct0 !== p.trig) begin n_bad++; $display("FAIL %s trig0: got %b want %b", p.name, ct0, p.trig); end
                if (d3 !== p.rdata) begin n_bad++; $display("FAIL %s rdata3: got %h want %h", p.name, d3, p.rdata); end
                if (e3 !== p.err) begin n_bad++; $display("FAIL %s err3: got %b want %b", p.name, e3, p.err); end
                if (t3 !== p.trig) begin n_bad++; $display("FAIL %s trig3: got %b want %b", p.name, t3, p.trig); end
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({r0, d0, e0, t0, r3, d3, e3, t3} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b/%h/%b/%b %b/%h/%b/%b want all zero", r0, d0, e0, t0, r3, d3, e3, t3);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch;
        load_word(4, 32'h0000_0013);
        run_req("fetch_0x10", 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_states;
        load_word(5, 32'h5A5A_1234);
        run_req("read_0x14", 1'b0, 32'h14, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_strobe_store;
        load_word(0, 32'h1122_3344);
        run_req("store_0101", 1'b0, 32'h0, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
        run_req("readback_0", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_out_of_range;
        run_req("oor_write", 1'b0, 32'h0001_0000, 32'hDEAD_0000, 4'hF, 1'b0, 32'h0);
        run_req("oor_read", 1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'h0);
        run_req("after_oor_0", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_collision;
        load_word(8, 32'h0BAD_F00D);
        run_req("collide_8", 1'b0, 32'h20, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'hCAFE_F00D);
        run_req("readback_8", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_trigger;
        run_req("trig_fetch", 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
        run_req("trig_load", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
        run_req("fetch_other", 1'b1, 32'h24, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        valid = 1'b1; instr = 1'b0; addr = 32'h10; wdata = '0; wstrb = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) valid = 1'b0;
            n_cmp += 2;
            if (r0 !== (k % 2 == 1 && k < 10)) begin
                n_bad++;
                $display("FAIL b2b ready0 k=%0d: got %b", k, r0);
            end
            if (r3 !== (k == 4 || k == 9)) begin
                n_bad++;
                $display("FAIL b2b ready3 k=%0d: got %b", k, r3);
            end
            if (r3 === 1'b1) begin
                n_cmp++;
                if (d3 !== model[4]) begin n_bad++; $display("FAIL b2b rdata3: got %h want %h", d3, model[4]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        valid = 1'b1; instr = 1'b1; addr = 32'h20; wdata = '0; wstrb = 4'h0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        n_cmp += 2;
        if (r0 !== 1'b1) begin n_bad++; $display("FAIL mid ready0: got %b want 1", r0); end
        if (t0 !== TRIG_ON) begin n_bad++; $display("FAIL mid trig0: got %b want %b", t0, TRIG_ON); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({r3, d3, e3, t3, r0, d0} !== '0) begin
            n_bad++;
            $display("FAIL mid reset outputs: got %b/%h/%b/%b %b/%h want zero", r3, d3, e3, t3, r0, d0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (r3 !== 1'b0 || t3 !== 1'b0) begin
                n_bad++;
                $display("FAIL mid aborted k=%0d: got ready %b trig %b want 0", k, r3, t3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = '0;
        test_reset;
        test_fetch;
        test_wait_states;
        test_strobe_store;
        test_out_of_range;
        test_collision;
        test_trigger;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
